sram_stream_ctrl: RTL

- Command-driven access controller that sits directly upstream of the 1024x32 single-port SRAM macro wrapper in the MAC engine memory path.
- Converts burst read/write commands with valid/ready data streams into the macro's active-low CEB/WEB/address/data pin protocol.
- Absorbs the macro's 1-cycle read latency in a 3-entry output FIFO, so read bursts run at 1 word/cycle under backpressure.
- Suppresses all accesses while scan_en_i is high, because the macro clock is gated in that mode.

---
 rtl/sram_stream_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sram_stream_ctrl.sv
// sram_stream_ctrl: burst command front-end for a single-port SRAM macro.
// Turns read/write burst commands plus valid/ready data streams into the
// macro's active-low CEB/WEB pin protocol. A 3-entry output FIFO absorbs the
// macro's 1-cycle read latency. No access is issued while scan_en_i is high.
module sram_stream_ctrl #(
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = $clog2(NUM_WORDS),
    parameter int unsigned LEN_W     = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              scan_en_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rdata_valid_o,
    input  logic              rdata_ready_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sram_ceb_o,
    output logic              sram_web_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_d_o,
    input  logic [DATA_W-1:0] sram_q_i
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [LEN_W-1:0]  remaining;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] d_hold;
    logic              inflight;

    logic [DATA_W-1:0] fifo_mem [3];
    logic [1:0]        fifo_count;
    logic [1:0]        rd_ptr;
    logic [1:0]        wr_ptr;
    logic [2:0]        credit_used;

    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_issue;
    logic              access;
    logic              push;
    logic              pop;

    // Reads in flight are counted against FIFO space so a push never overflows.
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight};
    assign next_addr   = (cur_addr == ADDR_W'(NUM_WORDS - 1)) ? '0 : cur_addr + ADDR_W'(1);

    assign cmd_fire = cmd_valid_i & cmd_ready_o;
    assign wr_fire  = wdata_valid_i & wdata_ready_o;
    assign access   = wr_fire | rd_issue;

    assign push          = inflight;
    assign rdata_valid_o = (fifo_count != 2'd0);
    assign pop           = rdata_valid_o & rdata_ready_i;
    assign rdata_o       = fifo_mem[rd_ptr];

    assign busy_o = (state != IDLE);

    // SRAM pins: driven only on an access cycle, otherwise addr/data hold.
    assign sram_ceb_o  = ~access;
    assign sram_web_o  = ~wr_fire;
    assign sram_addr_o = access ? cur_addr : addr_hold;
    assign sram_d_o    = wr_fire ? wdata_i : d_hold;

    // Next-state decode and per-state handshake/issue outputs.
    always_comb begin
        state_next    = state;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        rd_issue      = 1'b0;
        done_o        = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    if (cmd_len_i == '0) begin
                        state_next = DONE;
                    end else if (cmd_write_i) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            WR: begin
                wdata_ready_o = ~scan_en_i;
                if (wdata_valid_i && !scan_en_i && remaining == LEN_W'(1)) begin
                    state_next = DONE;
                end
            end
            RD: begin
                rd_issue = (remaining != '0) && !scan_en_i && (credit_used < 3'd3);
                if (remaining == '0 && !inflight && fifo_count == 2'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Burst address/length tracking, pin hold values and read-in-flight flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_addr  <= '0;
            remaining <= '0;
            addr_hold <= '0;
            d_hold    <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= rd_issue;
            if (cmd_fire) begin
                cur_addr  <= cmd_addr_i;
                remaining <= cmd_len_i;
            end else if (access) begin
                cur_addr  <= next_addr;
                remaining <= remaining - LEN_W'(1);
            end
            if (access) begin
                addr_hold <= cur_addr;
            end
            if (wr_fire) begin
                d_hold <= wdata_i;
            end
        end
    end

    // Read-data FIFO: push the word captured from the macro, pop on consume.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 3; i++) begin
                fifo_mem[i] <= '0;
            end
            fifo_count <= 2'd0;
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sram_q_i;
                wr_ptr           <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
